iq: RTL and testbench

//  Instruction queue between fetch and decode. It buffers up to 2^CONFIG_P_IQ_DEPTH fetched

---
 rtl/iq_pkg.sv | 37 +++
 rtl/iq_ram.sv | 37 +++
 rtl/iq.sv | 121 ++++++++++++
 tb/tb_iq.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/iq_pkg.sv
// Shared widths, instruction-queue entry layout and the leading-ones counter used by the iq.
// Entry layout, MSB to LSB: ins | pc | exc | bpu_upd.
package iq_pkg;

    localparam int NCPU_INSN_DW = 32;
    localparam int FNT_EXC_W    = 4;
    localparam int BPU_UPD_W    = 8;

    localparam int IQ_ENT_BPU_UPD_LSB = 0;
    localparam int IQ_ENT_EXC_LSB     = IQ_ENT_BPU_UPD_LSB + BPU_UPD_W;
    localparam int IQ_ENT_PC_LSB      = IQ_ENT_EXC_LSB + FNT_EXC_W;

    // The pc field width belongs to the instantiator, so the ins offset and total width follow it.
    function automatic int iq_ent_ins_lsb(input int aw);
        return IQ_ENT_PC_LSB + aw;
    endfunction

    function automatic int iq_ent_w(input int aw);
        return iq_ent_ins_lsb(aw) + NCPU_INSN_DW;
    endfunction

    // Count consecutive ones starting from bit 0.
    function automatic int clo(input logic [31:0] v);
        int   n;
        logic run;
        n   = 0;
        run = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (run && v[i])
                n = n + 1;
            else
                run = 1'b0;
        end
        return n;
    endfunction

endpackage

// File: rtl/iq_ram.sv
// Payload storage for the instruction queue: flop array, FW write ports at consecutive
// addresses from waddr, IW combinational read ports at consecutive addresses from raddr.
module iq_ram
    import iq_pkg::*;
#(
    parameter int P_FW = 1,
    parameter int P_IW = 1,
    parameter int P_D  = 3,
    parameter int EW   = 8
) (
    input  logic                        clk,
    input  logic [P_D-1:0]              waddr,
    input  logic [P_FW:0]               wcnt,
    input  logic [EW*(1<<P_FW)-1:0]     wdata,
    input  logic [P_D-1:0]              raddr,
    output logic [EW*(1<<P_IW)-1:0]     rdata
);

    localparam int FW    = 1 << P_FW;
    localparam int IW    = 1 << P_IW;
    localparam int DEPTH = 1 << P_D;

    logic [EW-1:0] mem [DEPTH];

    // Addresses wrap naturally through the P_D-bit sum.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FW; i++) begin
            if ((P_FW+1)'(i) < wcnt)
                mem[waddr + P_D'(i)] <= wdata[i*EW +: EW];
        end
    end

    for (genvar gi = 0; gi < IW; gi++) begin : g_rd
        assign rdata[gi*EW +: EW] = mem[raddr + P_D'(gi)];
    end

endmodule

// File: rtl/iq.sv
// Instruction queue between fetch and decode: accepts packed fetch bundles, presents the
// oldest IW entries to id combinationally and retires what id reports as consumed.
module iq
    import iq_pkg::*;
#(
    parameter int CONFIG_AW            = 32,  // pc width; set by the instantiator
    parameter int CONFIG_P_FETCH_WIDTH = 1,
    parameter int CONFIG_P_ISSUE_WIDTH = 1,
    parameter int CONFIG_P_IQ_DEPTH    = 3
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         flush,
    input  logic                                         stall,
    input  logic [(1<<CONFIG_P_FETCH_WIDTH)-1:0]         iq_valid,
    input  logic [NCPU_INSN_DW*(1<<CONFIG_P_FETCH_WIDTH)-1:0] iq_ins,
    input  logic [CONFIG_AW*(1<<CONFIG_P_FETCH_WIDTH)-1:0]    iq_pc,
    input  logic [FNT_EXC_W*(1<<CONFIG_P_FETCH_WIDTH)-1:0]    iq_exc,
    input  logic [BPU_UPD_W*(1<<CONFIG_P_FETCH_WIDTH)-1:0]    iq_bpu_upd,
    output logic                                         iq_ready,
    output logic [(1<<CONFIG_P_ISSUE_WIDTH)-1:0]         id_valid,
    output logic [NCPU_INSN_DW*(1<<CONFIG_P_ISSUE_WIDTH)-1:0] id_ins,
    output logic [CONFIG_AW*(1<<CONFIG_P_ISSUE_WIDTH)-1:0]    id_pc,
    output logic [FNT_EXC_W*(1<<CONFIG_P_ISSUE_WIDTH)-1:0]    id_exc,
    output logic [BPU_UPD_W*(1<<CONFIG_P_ISSUE_WIDTH)-1:0]    id_bpu_upd,
    input  logic [CONFIG_P_ISSUE_WIDTH:0]                id_pop_cnt
);

    localparam int P_FW    = CONFIG_P_FETCH_WIDTH;
    localparam int P_IW    = CONFIG_P_ISSUE_WIDTH;
    localparam int P_D     = CONFIG_P_IQ_DEPTH;
    localparam int FW      = 1 << P_FW;
    localparam int IW      = 1 << P_IW;
    localparam int DEPTH   = 1 << P_D;
    localparam int EW      = iq_ent_w(CONFIG_AW);
    localparam int INS_LSB = iq_ent_ins_lsb(CONFIG_AW);

    logic [P_D-1:0] head_reg, head_next;
    logic [P_D-1:0] tail_reg, tail_next;
    logic [P_D:0]   count_reg, count_next;

    logic           push;
    logic [P_FW:0]  push_cnt;
    logic [P_IW:0]  pop_cnt;

    logic [EW*FW-1:0] wdata;
    logic [EW*IW-1:0] rdata;

    // Readiness looks only at registered occupancy, so there is no comb path from id to fetch.
    assign iq_ready = ({1'b0, count_reg} + (P_D+2)'(FW)) <= (P_D+2)'(DEPTH);
    assign push     = iq_ready & iq_valid[0];
    assign push_cnt = push ? (P_FW+1)'(clo(32'(iq_valid))) : '0;
    assign pop_cnt  = stall ? '0 : id_pop_cnt;

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (flush) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            head_next  = head_reg + P_D'(pop_cnt);
            tail_next  = tail_reg + P_D'(push_cnt);
            count_next = count_reg + (P_D+1)'(push_cnt) - (P_D+1)'(pop_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    for (genvar gi = 0; gi < FW; gi++) begin : g_wpack
        assign wdata[gi*EW +: EW] = {iq_ins[gi*NCPU_INSN_DW +: NCPU_INSN_DW],
                                     iq_pc[gi*CONFIG_AW +: CONFIG_AW],
                                     iq_exc[gi*FNT_EXC_W +: FNT_EXC_W],
                                     iq_bpu_upd[gi*BPU_UPD_W +: BPU_UPD_W]};
    end

    // A flushed cycle must not write; the pointers are reset anyway but keep the array quiet.
    iq_ram #(
        .P_FW (P_FW),
        .P_IW (P_IW),
        .P_D  (P_D),
        .EW   (EW)
    ) u_ram (
        .clk   (clk),
        .waddr (tail_reg),
        .wcnt  ((flush | rst) ? '0 : push_cnt),
        .wdata (wdata),
        .raddr (head_reg),
        .rdata (rdata)
    );

    for (genvar gi = 0; gi < IW; gi++) begin : g_rd
        assign id_valid[gi] = (P_D+1)'(gi) < count_reg;
        assign id_ins[gi*NCPU_INSN_DW +: NCPU_INSN_DW] = rdata[gi*EW + INS_LSB +: NCPU_INSN_DW];
        assign id_pc[gi*CONFIG_AW +: CONFIG_AW]        = rdata[gi*EW + IQ_ENT_PC_LSB +: CONFIG_AW];
        assign id_exc[gi*FNT_EXC_W +: FNT_EXC_W]       = rdata[gi*EW + IQ_ENT_EXC_LSB +: FNT_EXC_W];
        assign id_bpu_upd[gi*BPU_UPD_W +: BPU_UPD_W]   = rdata[gi*EW + IQ_ENT_BPU_UPD_LSB +: BPU_UPD_W];
    end

    // Illegal-input checks; popping beyond count also covers popping an invalid slot.
    always @(posedge clk) begin
        if (!rst) begin
            assert ((iq_valid & (iq_valid + 1'b1)) == '0);
            assert (id_pop_cnt <= (P_IW+1)'(IW));
            assert ((P_D+1)'(id_pop_cnt) <= count_reg);
        end
    end

endmodule

// File: tb/tb_iq.sv
// Randomised and directed bench for iq (FW=2, IW=2, 8 entries) against a queue-based model.
module tb_iq;

    localparam int AW = 32;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [3:0]  exc;
        logic [7:0]  bpu;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst, flush, stall;
    logic [1:0]    iq_valid;
    logic [63:0]   iq_ins;
    logic [63:0]   iq_pc;
    logic [7:0]    iq_exc;
    logic [15:0]   iq_bpu_upd;
    logic          iq_ready;
    logic [1:0]    id_valid;
    logic [63:0]   id_ins;
    logic [63:0]   id_pc;
    logic [7:0]    id_exc;
    logic [15:0]   id_bpu_upd;
    logic [1:0]    id_pop_cnt;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_cyc    = 0;
    ent_t q[$];

    always #5 clk = ~clk;

    iq #(
        .CONFIG_AW            (AW),
        .CONFIG_P_FETCH_WIDTH (1),
        .CONFIG_P_ISSUE_WIDTH (1),
        .CONFIG_P_IQ_DEPTH    (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .stall      (stall),
        .iq_valid   (iq_valid),
        .iq_ins     (iq_ins),
        .iq_pc      (iq_pc),
        .iq_exc     (iq_exc),
        .iq_bpu_upd (iq_bpu_upd),
        .iq_ready   (iq_ready),
        .id_valid   (id_valid),
        .id_ins     (id_ins),
        .id_pc      (id_pc),
        .id_exc     (id_exc),
        .id_bpu_upd (id_bpu_upd),
        .id_pop_cnt (id_pop_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, n_cyc, got, exp);
        end
    endtask

    // One clock: drive a bundle of nv insns (pcs from pcb step 4), compare outputs, step model.
    task automatic cycle(input int nv, input logic [31:0] pcb, input int pop,
                         input bit stl, input bit fl);
        ent_t bun [2];
        int   p;
        int   sz;
        bit   rdy;
        p = (pop > q.size()) ? q.size() : pop;
        if (p > 2) p = 2;
        for (int i = 0; i < 2; i++) begin
            bun[i].ins = $urandom;
            bun[i].pc  = pcb + 32'(4 * i);
            bun[i].exc = 4'($urandom);
            bun[i].bpu = 8'($urandom);
            iq_ins[i*32 +: 32]    = bun[i].ins;
            iq_pc[i*32 +: 32]     = bun[i].pc;
            iq_exc[i*4 +: 4]      = bun[i].exc;
            iq_bpu_upd[i*8 +: 8]  = bun[i].bpu;
        end
        iq_valid   = (nv >= 2) ? 2'b11 : (nv == 1) ? 2'b01 : 2'b00;
        id_pop_cnt = 2'(p);
        stall      = stl;
        flush      = fl;

        @(negedge clk);
        sz  = q.size();
        rdy = (8 - sz) >= 2;
        check("iq_ready", 64'(iq_ready), 64'(rdy));
        check("id_valid", 64'(id_valid), (sz >= 2) ? 64'd3 : 64'(sz));
        for (int i = 0; i < 2 && i < sz; i++) begin
            check($sformatf("id_pc[%0d]", i),  64'(id_pc[i*32 +: 32]), 64'(q[i].pc));
            check($sformatf("id_ins[%0d]", i), 64'(id_ins[i*32 +: 32]), 64'(q[i].ins));
            check($sformatf("id_side[%0d]", i), 64'({id_exc[i*4 +: 4], id_bpu_upd[i*8 +: 8]}),
                  64'({q[i].exc, q[i].bpu}));
        end

        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (!stl)
                for (int i = 0; i < p; i++) void'(q.pop_front());
            if (rdy)
                for (int i = 0; i < nv && i < 2; i++) q.push_back(bun[i]);
        end
        #1;
        n_cyc++;
        $display("cyc=%0d push=%0d pop=%0d stall=%0d flush=%0d ready=%0d occ=%0d",
                 n_cyc, nv, p, stl, fl, rdy, q.size());
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall = 1'b0;
        iq_valid = '0; iq_ins = '0; iq_pc = '0; iq_exc = '0; iq_bpu_upd = '0; id_pop_cnt = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset/idle, then a first push of two.
        cycle(0, 32'h0, 0, 0, 0);
        cycle(2, 32'h100, 0, 0, 0);
        cycle(0, 32'h0, 0, 0, 0);

        // Fill to eight, held fifth bundle, then pop two.
        cycle(0, 32'h0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(2, 32'h200 + 32'(8 * i), 0, 0, 0);
        cycle(2, 32'h900, 0, 0, 0);
        cycle(0, 32'h0, 2, 0, 0);
        cycle(0, 32'h0, 0, 0, 0);

        // Wrap: push 6, pop 6, push 4, drain singly.
        cycle(0, 32'h0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(2, 32'h300 + 32'(8 * i), 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 32'h0, 2, 0, 0);
        for (int i = 0; i < 2; i++) cycle(2, 32'h400 + 32'(8 * i), 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 32'h0, 1, 0, 0);

        // Simultaneous push/pop at count 3, stall with push, flush with push and pop.
        cycle(2, 32'h500, 0, 0, 0);
        cycle(1, 32'h510, 0, 0, 0);
        cycle(2, 32'h520, 2, 0, 0);
        cycle(2, 32'h530, 2, 1, 0);
        cycle(2, 32'h540, 2, 0, 1);
        cycle(2, 32'h600, 0, 0, 0);
        cycle(0, 32'h0, 1, 0, 0);

        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 2), $urandom & 32'hffff_fffc, $urandom_range(0, 2),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 40) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
